// File: rtl/ex_div_pkg.sv
// Shared types and constants for the RV32M divide/remainder unit.
package ex_div_pkg;

  localparam int XLEN = 32;

  // func7 of the M-extension instructions (MUL*/DIV*/REM*).
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    CALC  = 2'd2,
    END   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    logic [XLEN-1:0] r;
    if (neg) begin
      r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU beside the execute stage.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);
  import ex_div_pkg::*;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [4:0]      rd_q, rd_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed_s;
  logic            is_rem_s;
  logic            div_zero_s;
  logic            overflow_s;
  logic [XLEN-1:0] dvd_mag_s;
  logic [XLEN-1:0] dvs_mag_s;
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN:0]   trial_s;
  logic            no_borrow_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic [XLEN-1:0] quot_nxt_s;

  assign is_signed_s = (op_q == OP_DIV) || (op_q == OP_REM);
  assign is_rem_s    = (op_q == OP_REM) || (op_q == OP_REMU);
  assign div_zero_s  = (dvs_q == {XLEN{1'b0}});
  assign overflow_s  = is_signed_s && (dvd_q == {1'b1, {(XLEN-1){1'b0}}})
                       && (dvs_q == {XLEN{1'b1}});
  assign dvd_mag_s   = neg_if(dvd_q, is_signed_s & dvd_q[XLEN-1]);
  assign dvs_mag_s   = neg_if(dvs_q, is_signed_s & dvs_q[XLEN-1]);

  // A shifted remainder with its top bit set always exceeds the divisor, so only
  // a 33-bit wrap of the trial subtraction signals a borrow.
  assign rem_sh_s    = {rem_q, quot_q[XLEN-1]};
  assign trial_s     = rem_sh_s - {1'b0, dvs_q};
  assign no_borrow_s = rem_sh_s[XLEN] | ~trial_s[XLEN];
  assign rem_nxt_s   = no_borrow_s ? trial_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quot_nxt_s  = {quot_q[XLEN-2:0], no_borrow_s};

  // Next-state and datapath update for the IDLE/START/CALC/END sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_d = START;
          op_d    = op_e'(op_i);
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          rd_d    = rd_addr_i;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (div_zero_s) begin
          result_d = is_rem_s ? dvd_q : {XLEN{1'b1}};
          state_d  = END;
        end else if (overflow_s) begin
          result_d = is_rem_s ? {XLEN{1'b0}} : dvd_q;
          state_d  = END;
        end else begin
          quot_d  = dvd_mag_s;
          rem_d   = {XLEN{1'b0}};
          dvs_d   = dvs_mag_s;
          negq_d  = is_signed_s & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
          negr_d  = is_signed_s & dvd_q[XLEN-1];
          cnt_d   = 6'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          quot_d = quot_nxt_s;
          rem_d  = rem_nxt_s;
          if (cnt_q == 6'd31) begin
            result_d = is_rem_s ? neg_if(rem_nxt_s, negr_q) : neg_if(quot_nxt_s, negq_q);
            state_d  = END;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_DIV;
      dvd_q    <= {XLEN{1'b0}};
      dvs_q    <= {XLEN{1'b0}};
      rd_q     <= 5'd0;
      cnt_q    <= 6'd0;
      quot_q   <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // Output decode: hold stalls the issuing instruction in its own cycle and drops in END.
  always_comb begin
    busy_o      = (state_q != IDLE);
    hold_flag_o = ((state_q == IDLE) & start_i & ~flush_i)
                  | (state_q == START) | (state_q == CALC);
    rd_wen_o    = (state_q == END) & ~flush_i;
    if (rd_wen_o) begin
      rd_data_o = result_q;
      rd_addr_o = rd_q;
    end else begin
      rd_data_o = {XLEN{1'b0}};
      rd_addr_o = 5'd0;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard testbench for ex_div: latency, signed/unsigned results, special cases, flush, reset.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        hold_flag_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .hold_flag_o(hold_flag_o),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sbv;
    logic [31:0] r;
    sa  = a;
    sbv = b;
    if (b == 32'd0) r = op[1] ? a : 32'hFFFFFFFF;
    else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) r = op[1] ? 32'd0 : 32'h80000000;
    else begin
      case (op)
        2'b00:   r = sa / sbv;
        2'b01:   r = a / b;
        2'b10:   r = sa % sbv;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // Issue one op, push its expectation, wait for the writeback and check it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_data, input int lat,
                        input string name);
    exp_t e;
    int c;
    bit seen;
    e.data = exp_data; e.addr = rd; e.lat = lat;
    sb.push_back(e);
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    step();
    start_i = 1'b0;
    c = 1; seen = 1'b0;
    while (!seen && c <= 60) begin
      if (rd_wen_o) seen = 1'b1;
      else begin
        step();
        c++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no rd_wen_o within 60 cycles, required at cycle %0d", name, e.lat);
    end else begin
      if (c !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, c, e.lat);
      end
      checks++;
      if (rd_data_o !== e.data) begin
        errors++;
        $display("FAIL %s data: got %h required %h", name, rd_data_o, e.data);
      end
      checks++;
      if (rd_addr_o !== e.addr) begin
        errors++;
        $display("FAIL %s addr: got %0d required %0d", name, rd_addr_o, e.addr);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00;
    dividend_i = 32'd0; divisor_i = 32'd0; rd_addr_i = 5'd0;
    repeat (3) step();
    checks++;
    if ({busy_o, hold_flag_o, rd_wen_o, rd_data_o, rd_addr_o} !== 40'd0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b hold=%b wen=%b data=%h addr=%0d required all 0",
               busy_o, hold_flag_o, rd_wen_o, rd_data_o, rd_addr_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy: got %b required 0", busy_o);
    end
  endtask

  task automatic test_divu_latency();
    exp_t e;
    bit wen_seen = 1'b0;
    e.data = 32'd14; e.addr = 5'd5; e.lat = 34;
    sb.push_back(e);
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd5; start_i = 1'b1;
    #1;
    checks++;
    if (hold_flag_o !== 1'b1) begin
      errors++;
      $display("FAIL latency hold c0: got %b required 1", hold_flag_o);
    end
    for (int c = 1; c <= 34; c++) begin
      step();
      start_i = 1'b0;
      checks++;
      if (hold_flag_o !== (c <= 33)) begin
        errors++;
        $display("FAIL latency hold c%0d: got %b required %b", c, hold_flag_o, (c <= 33));
      end
      checks++;
      if (rd_wen_o !== (c == 34)) begin
        errors++;
        $display("FAIL latency wen c%0d: got %b required %b", c, rd_wen_o, (c == 34));
      end
      if (rd_wen_o && !wen_seen) begin
        wen_seen = 1'b1;
        e = sb.pop_front();
        checks++;
        if (rd_data_o !== e.data || rd_addr_o !== e.addr) begin
          errors++;
          $display("FAIL latency result: got %h/%0d required %h/%0d",
                   rd_data_o, rd_addr_o, e.data, e.addr);
        end
      end
    end
    if (!wen_seen) void'(sb.pop_front());
    step();
    checks++;
    if ({busy_o, rd_wen_o, rd_data_o, rd_addr_o} !== 39'd0) begin
      errors++;
      $display("FAIL latency after END: got busy=%b wen=%b data=%h addr=%0d required all 0",
               busy_o, rd_wen_o, rd_data_o, rd_addr_o);
    end
  endtask

  task automatic test_results();
    run_op(2'b00, -32'sd100, 32'd7, 5'd1, 32'hFFFFFFF2, 34, "div_neg");
    run_op(2'b10, -32'sd100, 32'd7, 5'd2, 32'hFFFFFFFE, 34, "rem_neg");
    run_op(2'b11, 32'hFFFFFFFF, 32'd16, 5'd3, 32'd15, 34, "remu_big");
    run_op(2'b00, 32'd7, -32'sd2, 5'd4, 32'hFFFFFFFD, 34, "div_negdivisor");
    run_op(2'b10, 32'd7, -32'sd2, 5'd6, 32'd1, 34, "rem_negdivisor");
    run_op(2'b00, 32'h80000000, 32'd2, 5'd7, 32'hC0000000, 34, "div_minint");
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'd0, 34, "divu_ovf_pattern");
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 34, "remu_ovf_pattern");
  endtask

  task automatic test_special();
    run_op(2'b00, 32'h12345678, 32'd0, 5'd10, 32'hFFFFFFFF, 2, "div_by_zero");
    run_op(2'b11, 32'h12345678, 32'd0, 5'd11, 32'h12345678, 2, "remu_by_zero");
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 2, "div_overflow");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 2, "rem_overflow");
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      lat = (b == 32'd0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 2 : 34;
      run_op(op, a, b, 5'(i + 14), model(op, a, b), lat, "random");
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    // Flush in the 10th CALC cycle.
    op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd20; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    flush_i = 1'b1;
    #1;
    checks++;
    if (rd_wen_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc wen: got %b required 0", rd_wen_o);
    end
    step();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc idle: got busy=%b hold=%b required 0/0", busy_o, hold_flag_o);
    end
    for (int c = 0; c < 40; c++) begin
      if (rd_wen_o) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL flush_calc pulses: got %0d required 0", pulses);
    end
    // Flush in the END cycle suppresses the writeback.
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd21; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (33) step();
    flush_i = 1'b1;
    #1;
    checks++;
    if (rd_wen_o !== 1'b0 || rd_data_o !== 32'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_end: got wen=%b data=%h busy=%b required 0/0/1",
               rd_wen_o, rd_data_o, busy_o);
    end
    step();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || rd_wen_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_end idle: got busy=%b wen=%b required 0/0", busy_o, rd_wen_o);
    end
    // start_i together with flush_i in IDLE is dropped.
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    checks++;
    if (hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle hold: got %b required 0", hold_flag_o);
    end
    step();
    start_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle busy: got %b required 0", busy_o);
    end
  endtask

  task automatic test_stray_start();
    int c = 1;
    int pulses = 0;
    bit seen = 1'b0;
    exp_t e;
    e.data = 32'd10; e.addr = 5'd3; e.lat = 34;
    sb.push_back(e);
    op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd3; start_i = 1'b1;
    step();
    dividend_i = 32'd77; divisor_i = 32'd7; rd_addr_i = 5'd9;
    while (!seen && c <= 60) begin
      if (rd_wen_o) seen = 1'b1;
      else begin
        step();
        c++;
      end
    end
    start_i = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!seen || c !== e.lat || rd_data_o !== e.data || rd_addr_o !== e.addr) begin
      errors++;
      $display("FAIL stray_start result: got seen=%b cycle=%0d data=%h addr=%0d required cycle=%0d data=%h addr=%0d",
               seen, c, rd_data_o, rd_addr_o, e.lat, e.data, e.addr);
    end
    step();
    for (int i = 0; i < 40; i++) begin
      if (rd_wen_o || busy_o) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL stray_start extra activity: got %0d cycles required 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd7; rd_addr_i = 5'd22; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy_o, hold_flag_o, rd_wen_o, rd_data_o, rd_addr_o} !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got busy=%b hold=%b wen=%b data=%h addr=%0d required all 0",
               busy_o, hold_flag_o, rd_wen_o, rd_data_o, rd_addr_o);
    end
    run_op(2'b01, 32'd9, 32'd3, 5'd23, 32'd3, 34, "divu_after_reset");
  endtask

  initial begin
    test_reset();
    test_divu_latency();
    test_results();
    test_special();
    test_random();
    test_flush();
    test_stray_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
